execute_muldiv: RTL and testbench
=================================

EXECUTE_MULDIV -- requirements
Module: execute_muldiv

Interface
REQ-001 Parameter XLEN, default 32, SHALL set operand and result width; legal values 32 and 64.
REQ-002 Parameter MUL_BITS, default 2, SHALL set multiplier bits retired per cycle; legal values 1, 2, 4, 8, each dividing XLEN.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 in_valid  in  1  SHALL indicate that an operation is offered.
REQ-006 in_ready  out  1  SHALL indicate that the block accepts an operation this cycle.
REQ-007 in_op  in  3  SHALL carry funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 in_rs1, in_rs2  in  XLEN  SHALL carry the operands.
REQ-009 in_rd  in  5  SHALL carry the destination register tag.
REQ-010 flush  in  1  SHALL abort any operation in progress.
REQ-011 out_valid  out  1, out_ready  in  1  SHALL form the result handshake.
REQ-012 out_result  out  XLEN, out_rd  out  5  SHALL carry the result and its tag.
REQ-013 busy  out  1  SHALL be high in every state except IDLE.
REQ-014 illegal  out  1  SHALL qualify out_valid for ops not compiled in (REQ-029).

Function
REQ-015 Accept SHALL occur when in_valid and in_ready are both high; in_ready SHALL be high only in IDLE with flush low.
REQ-016 The FSM SHALL have states IDLE, MUL, DIV, DONE.
REQ-017 On accept: ops 0-3 go to MUL; ops 4-7 go to DIV, or to DONE directly for the special cases in REQ-021/022.
REQ-018 MUL SHALL run XLEN/MUL_BITS cycles, then go to DONE; DIV SHALL run XLEN cycles, then go to DONE.
REQ-019 In DONE, out_valid SHALL be high; out_result and out_rd SHALL stay stable until out_ready is high, after which the FSM returns to IDLE on the next edge.
REQ-020 Signedness: MULH s*s, MULHSU s*u, MULHU u*u; MUL returns low XLEN bits, the H variants return high XLEN bits of the 2*XLEN product.
REQ-021 Divide by zero: quotient all ones, remainder = rs1; DONE one cycle after accept.
REQ-022 Signed overflow (rs1 = most negative, rs2 = -1, DIV/REM): quotient = rs1, remainder = 0; DONE one cycle after accept.
REQ-023 Signed divide SHALL truncate toward zero; remainder sign SHALL follow the dividend.
REQ-024 flush SHALL force IDLE on the next edge from any state, drop out_valid, and block accept in the same cycle.
REQ-025 Operands and tag SHALL be captured at accept; later changes to in_* SHALL have no effect.

Reset
REQ-026 rst SHALL force IDLE, out_valid=0, busy=0, illegal=0, out_result=0, out_rd=0, and clear all datapath registers.
REQ-027 rst asserted mid-operation SHALL discard that operation; no out_valid SHALL follow.
REQ-028 in_ready SHALL be low while rst is high and high in the first cycle after release.

Configuration
REQ-029 Macro EXECUTE_MULDIV_DIV_EN: when defined, ops 4-7 SHALL execute per REQ-018/021-023. When undefined, no divider logic SHALL exist, and ops 4-7 SHALL go to DONE one cycle after accept with out_result=0 and illegal=1.

Structure
REQ-030 Op encoding enum, FSM state enum, and XLEN default SHALL live in the shared package alongside the existing pipeline types.
REQ-031 Sub-module muldiv_divider SHALL hold the radix-2 restoring divider, instantiated only under EXECUTE_MULDIV_DIV_EN; the multiplier SHALL stay in execute_muldiv.

Verification
REQ-032 MUL 7*6, XLEN=32, MUL_BITS=2 -> out_valid 17 cycles after accept, out_result=42.
REQ-033 MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
REQ-034 DIV -7/2 -> 0xFFFFFFFD; REM -7%2 -> 0xFFFFFFFF; DIVU 100/7 -> 14 after 33 cycles.
REQ-035 DIV 5/0 -> 0xFFFFFFFF; REM 5%0 -> 5; DIV 0x80000000/-1 -> 0x80000000; each with out_valid one cycle after accept.
REQ-036 out_ready held low 10 cycles in DONE -> result stable; flush in cycle 5 of a DIV -> IDLE next cycle, out_valid never asserted.
REQ-037 Build without EXECUTE_MULDIV_DIV_EN, issue DIVU -> illegal=1, out_result=0, out_valid one cycle after accept.

Source files
------------

// File: rtl/execute_muldiv_pkg.sv
// Shared execute-stage types for the multiply/divide unit.
// Holds the pipeline register-tag type, the funct3 op encoding, the muldiv FSM
// state encoding and the default operand width.
package execute_muldiv_pkg;

  localparam int unsigned XlenDefault = 32;

  // Pipeline-wide destination register tag.
  typedef logic [4:0] reg_addr_t;

  // funct3 of the RV M-extension.
  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhsu = 3'd2,
    OpMulhu  = 3'd3,
    OpDiv    = 3'd4,
    OpDivu   = 3'd5,
    OpRem    = 3'd6,
    OpRemu   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2,
    StDone = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_divider.sv
// Radix-2 restoring divider on unsigned magnitudes; one quotient bit per step.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   start_i            load dividend/divisor and clear the partial remainder
//   step_i             retire one quotient bit
//   dividend_i         unsigned dividend, sampled on start_i
//   divisor_i          unsigned divisor (non-zero), sampled on start_i
//   quotient_o         quotient after the step taken this cycle
//   remainder_o        partial remainder after the step taken this cycle
// After Width steps quotient_o/remainder_o hold the final result during the last step.
module muldiv_divider #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             step_i,
  input  logic [Width-1:0] dividend_i,
  input  logic [Width-1:0] divisor_i,
  output logic [Width-1:0] quotient_o,
  output logic [Width-1:0] remainder_o
);

  logic [Width-1:0] quo_q, quo_d;
  logic [Width-1:0] rem_q, rem_d;
  logic [Width-1:0] dvs_q, dvs_d;
  logic [Width:0]   trial;
  logic [Width:0]   diff;
  logic             fits;

  always_comb begin
    // Shift the next dividend bit into the partial remainder and try the subtract.
    trial       = {rem_q, quo_q[Width-1]};
    diff        = trial - {1'b0, dvs_q};
    fits        = (trial >= {1'b0, dvs_q});
    quotient_o  = {quo_q[Width-2:0], fits};
    remainder_o = fits ? diff[Width-1:0] : trial[Width-1:0];

    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    if (start_i) begin
      quo_d = dividend_i;
      rem_d = '0;
      dvs_d = divisor_i;
    end else if (step_i) begin
      quo_d = quotient_o;
      rem_d = remainder_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

endmodule

// File: rtl/execute_muldiv.sv
// Iterative RV M-extension execute unit: shift-add multiplier retiring MUL_BITS
// multiplier bits per cycle, plus an optional radix-2 restoring divider.
// Configuration macro: EXECUTE_MULDIV_DIV_EN enables the divider; without it,
// ops 4-7 complete one cycle after accept with out_result=0 and illegal=1.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operation handshake (ready only in IDLE, no flush)
//   in_op, in_rs1, in_rs2    funct3 and operands, captured at accept
//   in_rd                    destination tag, captured at accept
//   flush                    abort any operation, back to IDLE on the next edge
//   out_valid/out_ready      result handshake, result held stable in DONE
//   out_result, out_rd       result and its tag
//   busy                     high whenever not IDLE
//   illegal                  marks a result for an op not compiled in
module execute_muldiv
  import execute_muldiv_pkg::*;
#(
  parameter int unsigned XLEN     = XlenDefault,
  parameter int unsigned MUL_BITS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [4:0]      in_rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            busy,
  output logic            illegal
);

  localparam int unsigned MulSteps = XLEN / MUL_BITS;
  localparam int unsigned CntW     = $clog2(XLEN);

  muldiv_state_e     state_q, state_d;
  muldiv_op_e        op_q, op_d;
  reg_addr_t         rd_q, rd_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              illegal_q, illegal_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic              neg_q, neg_d;

  muldiv_op_e      in_op_e;
  logic            rs1_neg, rs2_neg;
  logic [XLEN-1:0] rs1_mag, rs2_mag;
  logic            accept;

  // Signed ops run on magnitudes; the sign is reapplied to the finished result.
  always_comb begin
    in_op_e = muldiv_op_e'(in_op);
    rs1_neg = in_rs1[XLEN-1] && (in_op_e inside {OpMulh, OpMulhsu, OpDiv, OpRem});
    rs2_neg = in_rs2[XLEN-1] && (in_op_e inside {OpMulh, OpDiv, OpRem});
    rs1_mag = rs1_neg ? -in_rs1 : in_rs1;
    rs2_mag = rs2_neg ? -in_rs2 : in_rs2;
  end

  assign in_ready   = (state_q == StIdle) && !flush && !rst;
  assign accept     = in_valid && in_ready;
  assign busy       = (state_q != StIdle);
  assign out_valid  = (state_q == StDone);
  assign out_result = result_q;
  assign out_rd     = rd_q;
  assign illegal    = illegal_q;

  // Shift-add step: add mcand * low digit into the upper half, then shift right.
  logic [MUL_BITS-1:0]      mul_digit;
  logic [XLEN+MUL_BITS-1:0] mul_sum;
  logic [2*XLEN-1:0]        prod_step;
  logic [2*XLEN-1:0]        mul_full;

  assign mul_digit = prod_q[MUL_BITS-1:0];
  assign mul_sum   = {{MUL_BITS{1'b0}}, prod_q[2*XLEN-1:XLEN]}
                   + ({{MUL_BITS{1'b0}}, mcand_q} * {{XLEN{1'b0}}, mul_digit});
  assign prod_step = {mul_sum, prod_q[XLEN-1:MUL_BITS]};
  assign mul_full  = neg_q ? -prod_step : prod_step;

`ifdef EXECUTE_MULDIV_DIV_EN
  logic            div_start;
  logic            div_step;
  logic            div_ovf;
  logic [XLEN-1:0] div_quo;
  logic [XLEN-1:0] div_rem;
  logic            rneg_q, rneg_d;

  assign div_step = (state_q == StDiv);
  assign div_ovf  = !in_op[0] && (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&in_rs2);

  muldiv_divider #(
    .Width (XLEN)
  ) u_divider (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (div_start),
    .step_i      (div_step),
    .dividend_i  (rs1_mag),
    .divisor_i   (rs2_mag),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    neg_d     = neg_q;
`ifdef EXECUTE_MULDIV_DIV_EN
    div_start = 1'b0;
    rneg_d    = rneg_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d      = in_op_e;
          rd_d      = in_rd;
          cnt_d     = '0;
          illegal_d = 1'b0;
          result_d  = '0;
          if (!in_op[2]) begin
            state_d = StMul;
            mcand_d = rs1_mag;
            prod_d  = {{XLEN{1'b0}}, rs2_mag};
            neg_d   = rs1_neg ^ rs2_neg;
          end else begin
            state_d = StDone;
`ifdef EXECUTE_MULDIV_DIV_EN
            // in_op[1] selects REM/REMU.
            if (in_rs2 == '0) begin
              result_d = in_op[1] ? in_rs1 : '1;
            end else if (div_ovf) begin
              result_d = in_op[1] ? '0 : in_rs1;
            end else begin
              state_d   = StDiv;
              div_start = 1'b1;
              neg_d     = rs1_neg ^ rs2_neg;
              rneg_d    = rs1_neg;
            end
`else
            illegal_d = 1'b1;
`endif
          end
        end
      end
      StMul: begin
        prod_d = prod_step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CntW'(MulSteps - 1)) begin
          state_d  = StDone;
          result_d = (op_q == OpMul) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
        end
      end
      StDiv: begin
`ifdef EXECUTE_MULDIV_DIV_EN
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(XLEN - 1)) begin
          state_d = StDone;
          if (op_q == OpRem || op_q == OpRemu) begin
            result_d = rneg_q ? -div_rem : div_rem;
          end else begin
            result_d = neg_q ? -div_quo : div_quo;
          end
        end
`else
        state_d = StIdle;
`endif
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= OpMul;
      rd_q      <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
      mcand_q   <= '0;
      prod_q    <= '0;
      neg_q     <= 1'b0;
`ifdef EXECUTE_MULDIV_DIV_EN
      rneg_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      prod_q    <= prod_d;
      neg_q     <= neg_d;
`ifdef EXECUTE_MULDIV_DIV_EN
      rneg_q    <= rneg_d;
`endif
    end
  end

endmodule

// File: tb/tb_execute_muldiv.sv
module tb_execute_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [31:0] in_rs1 = '0;
  logic [31:0] in_rs2 = '0;
  logic [4:0]  in_rd = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        busy;
  logic        illegal;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  execute_muldiv #(
    .XLEN     (32),
    .MUL_BITS (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_rd      (in_rd),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .busy       (busy),
    .illegal    (illegal)
  );

`ifdef EXECUTE_MULDIV_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  // Reference model: plain 64-bit / int arithmetic on the architectural rules.
  function automatic logic [31:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int si, sj;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    si = a;
    sj = b;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      default: begin
        if (!DivEn) return 32'd0;
        if (b == 0) return (op[1]) ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return (op[1]) ? 32'd0 : a;
        case (op)
          3'd4: return si / sj;
          3'd5: return a / b;
          3'd6: return si % sj;
          default: return a % b;
        endcase
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    if (op < 3'd4) return 32 / 2 + 1;
    if (!DivEn) return 1;
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Offer one op, scramble inputs after accept, count cycles until out_valid.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int lat, output logic [31:0] res,
                       output logic [4:0] ord, output logic ill);
    int n;
    in_op = op; in_rs1 = a; in_rs2 = b; in_rd = rd; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_op = 3'($urandom); in_rs1 = $urandom; in_rs2 = $urandom; in_rd = 5'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    res = out_result; ord = out_rd; ill = illegal;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready got=%b want=0", in_ready);
    end
    vectors++;
    if ({out_valid, busy, illegal, out_result, out_rd} !== 39'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b b=%b i=%b r=%h rd=%0d want all zero",
               out_valid, busy, illegal, out_result, out_rd);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got=%b want=1", in_ready);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[10];
    int lat;
    logic [31:0] res, exp_r;
    logic [4:0] ord;
    logic ill;
    int exp_lat;
    v[0] = '{3'd0, 32'd7,          32'd6,          32'd42,         17};
    v[1] = '{3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  17};
    v[2] = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  17};
    v[3] = '{3'd2, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  17};
    v[4] = '{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
    v[5] = '{3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
    v[6] = '{3'd5, 32'd100,        32'd7,          32'd14,         33};
    v[7] = '{3'd4, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    v[8] = '{3'd6, 32'd5,          32'd0,          32'd5,          1};
    v[9] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    for (int i = 0; i < 10; i++) begin
      exp_r   = v[i].r;
      exp_lat = v[i].lat;
      if (!DivEn && v[i].op >= 3'd4) begin
        exp_r   = 32'd0;
        exp_lat = 1;
      end
      issue(v[i].op, v[i].a, v[i].b, 5'(i + 3), lat, res, ord, ill);
      vectors++;
      if (res !== exp_r) begin
        errors++; $display("FAIL directed_result[%0d] got=%h want=%h", i, res, exp_r);
      end
      vectors++;
      if (lat != exp_lat) begin
        errors++; $display("FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, exp_lat);
      end
      vectors++;
      if (ill !== (!DivEn && v[i].op >= 3'd4)) begin
        errors++; $display("FAIL directed_illegal[%0d] got=%b want=%b", i, ill,
                           (!DivEn && v[i].op >= 3'd4));
      end
      release_result();
    end
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [31:0] a, b, res;
    logic [4:0] rd, ord;
    logic ill;
    int lat;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      rd = 5'($urandom);
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 100);
        default: ;
      endcase
      issue(op, a, b, rd, lat, res, ord, ill);
      vectors++;
      if (res !== model_result(op, a, b) || ord !== rd || lat != model_lat(op, a, b)) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h got r=%h rd=%0d lat=%0d want r=%h rd=%0d lat=%0d",
                 i, op, a, b, res, ord, lat, model_result(op, a, b), rd, model_lat(op, a, b));
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      release_result();
    end
  endtask

  task automatic test_stall();
    logic [31:0] a, b, res;
    logic [4:0] ord;
    logic ill;
    int lat;
    a = $urandom;
    b = $urandom;
    issue(3'd1, a, b, 5'd17, lat, res, ord, ill);
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_result !== model_result(3'd1, a, b) || out_rd !== 5'd17) begin
        errors++;
        $display("FAIL stall_hold[%0d] got v=%b r=%h rd=%0d want v=1 r=%h rd=17",
                 i, out_valid, out_result, out_rd, model_result(3'd1, a, b));
      end
      @(posedge clk); #1;
    end
    release_result();
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL stall_release got v=%b busy=%b want 0/0", out_valid, busy);
    end
  endtask

  task automatic test_flush();
    logic seen;
    in_op = DivEn ? 3'd5 : 3'd0; in_rs1 = 32'd1000; in_rs2 = 32'd3; in_rd = 5'd9;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    in_valid = 1'b1;
    vectors++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_blocks_accept got in_ready=%b want=0", in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL flush_idle got busy=%b want=0", busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL flush_no_valid got seen=%b want=0", seen);
    end
  endtask

  task automatic test_rst_mid();
    logic seen;
    in_op = 3'd3; in_rs1 = $urandom; in_rs2 = $urandom; in_rd = 5'd4;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if (busy !== 1'b0 || out_result !== 32'd0 || out_rd !== 5'd0) begin
      errors++;
      $display("FAIL rst_mid_clear got busy=%b r=%h rd=%0d want 0/0/0", busy, out_result, out_rd);
    end
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL rst_mid_no_valid got seen=%b want=0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, res;
    logic [4:0] ord;
    logic ill;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = $urandom;
      issue(3'(i % 4), a, b, 5'(20 + i), lat, res, ord, ill);
      vectors++;
      if (res !== model_result(3'(i % 4), a, b) || ord !== 5'(20 + i)) begin
        errors++;
        $display("FAIL back_to_back[%0d] got r=%h rd=%0d want r=%h rd=%0d",
                 i, res, ord, model_result(3'(i % 4), a, b), 20 + i);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_flush();
    test_rst_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
